adc_spi_sampler: RTL and testbench

Parametrised multi-channel successor to the single-channel 16-bit ADC host in the lock-in front end. It drives N_CH serial ADCs that share CONVST and SCLK, each with its own SDO line. It runs continuous conversion frames with programmable timing and optional offset-binary to two's-complement conversion. It also supports power-of-two oversampling/averaging, and delivers one packed result word with a one-cycle valid strobe to the demodulator.

---
 rtl/adc_spi_sampler_if.sv | 13 +
 rtl/adc_spi_sampler.sv | 108 ++++++++++
 tb/tb_adc_spi_sampler.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/adc_spi_sampler_if.sv
// adc_spi_sampler_if: ADC-side serial lines plus the packed result/strobe toward the demodulator
interface adc_spi_sampler_if #(
  parameter int N_CH = 2,
  parameter int DATA_W = 16
);
  logic CONVST;
  logic SCLK;
  logic [N_CH-1:0] SDO;
  logic [N_CH*DATA_W-1:0] data;
  logic newdata;
  modport master (output CONVST, SCLK, data, newdata, input SDO);
  modport slave (input CONVST, SCLK, data, newdata, output SDO);
endinterface

// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: multi-channel serial ADC host with continuous frames and power-of-two averaging
module adc_spi_sampler #(
  parameter int DATA_W = 16,
  parameter int N_CH = 2,
  parameter int SCLK_DIV = 1,
  parameter int T_CONV = 36,
  parameter int T_QUIET = 4,
  parameter int OSR_LOG2 = 0,
  parameter int SIGNED = 0
) (
  input logic clk,
  input logic rst,
  input logic enable,
  adc_spi_sampler_if.master bus
);
  localparam int AW = DATA_W + OSR_LOG2;
  localparam int FW = OSR_LOG2 > 0 ? OSR_LOG2 : 1;
  localparam int CW = $clog2(T_CONV + SCLK_DIV + T_QUIET + 1);
  localparam int BW = $clog2(DATA_W + 1);
  localparam bit SGN = SIGNED != 0;
  localparam logic [DATA_W-1:0] FLIP = SGN ? {1'b1, {(DATA_W-1){1'b0}}} : '0;
  typedef enum logic [1:0] {IDLE, CONV, SHIFT, QUIET} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bits;
  logic [FW-1:0] frame;
  logic last;
  logic [N_CH-1:0][DATA_W-1:0] sr, avg;
  logic [N_CH-1:0][AW-1:0] acc, sum;
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      sum[i] = (frame == '0 ? '0 : acc[i]) + (SGN ? AW'($signed(sr[i] ^ FLIP)) : AW'(sr[i]));
      avg[i] = SGN ? DATA_W'($signed(sum[i]) >>> OSR_LOG2) : DATA_W'(sum[i] >> OSR_LOG2);
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bits <= '0;
      frame <= '0;
      last <= 1'b0;
      sr <= '0;
      acc <= '0;
      bus.CONVST <= 1'b0;
      bus.SCLK <= 1'b0;
      bus.data <= '0;
      bus.newdata <= 1'b0;
    end else if (!enable) begin
      state <= IDLE;
      cnt <= '0;
      bits <= '0;
      frame <= '0;
      last <= 1'b0;
      acc <= '0;
      bus.CONVST <= 1'b0;
      bus.SCLK <= 1'b0;
      bus.newdata <= 1'b0;
    end else begin
      bus.newdata <= 1'b0;
      // the word completed on the previous edge is folded into the running group here
      if (last) begin
        last <= 1'b0;
        if (frame == FW'(2 ** OSR_LOG2 - 1)) begin
          bus.data <= avg;
          bus.newdata <= 1'b1;
          frame <= '0;
        end else begin
          acc <= sum;
          frame <= frame + 1'b1;
        end
      end
      case (state)
        IDLE: begin
          state <= CONV;
          bus.CONVST <= 1'b1;
          cnt <= '0;
        end
        CONV:
          if (cnt == CW'(T_CONV - 1)) begin
            state <= SHIFT;
            bus.CONVST <= 1'b0;
            bus.SCLK <= 1'b1;
            cnt <= '0;
            bits <= '0;
          end else cnt <= cnt + 1'b1;
        SHIFT:
          if (cnt != CW'(SCLK_DIV - 1)) cnt <= cnt + 1'b1;
          else begin
            cnt <= '0;
            if (bus.SCLK) begin
              bus.SCLK <= 1'b0;
              for (int i = 0; i < N_CH; i++) sr[i] <= {sr[i][DATA_W-2:0], bus.SDO[i]};
              bits <= bits + 1'b1;
              last <= bits == BW'(DATA_W - 1);
            end else if (bits == BW'(DATA_W)) state <= QUIET;
            else bus.SCLK <= 1'b1;
          end
        QUIET:
          if (cnt == CW'(T_QUIET - 1)) begin
            state <= CONV;
            bus.CONVST <= 1'b1;
            cnt <= '0;
          end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_adc_spi_sampler.sv
// tb_adc_spi_sampler: four differently configured samplers checked every cycle against a frame-position model
module tb_adc_spi_sampler;
  localparam int DW = 16, NC = 2, NI = 4, NFR = 64, TC = 36;
  function automatic int c_div(int g); return g == 3 ? 3 : 1; endfunction
  function automatic int c_tq(int g); return g == 3 ? 1 : 4; endfunction
  function automatic int c_osr(int g); return g == 1 ? 2 : 0; endfunction
  function automatic int c_sgn(int g); return (g == 1 || g == 2) ? 1 : 0; endfunction
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0;
  int n_chk = 0, n_pass = 0;
  logic [DW-1:0] words [NI][NFR][NC];
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic fill_rand();
    for (int g = 0; g < NI; g++)
      for (int f = 0; f < NFR; f++)
        for (int c = 0; c < NC; c++) begin
          int r;
          r = $urandom_range(0, 7);
          words[g][f][c] = r == 0 ? 16'h0000 : r == 1 ? 16'hFFFF : r == 2 ? 16'h8000 : r == 3 ? 16'h7FFF : 16'($urandom);
        end
  endtask
  task automatic fill_const(input int g);
    for (int f = 0; f < NFR; f++) begin
      words[g][f][0] = 16'hA5C3;
      words[g][f][1] = 16'h0001;
    end
  endtask
  for (genvar g = 0; g < NI; g++) begin : inst
    localparam int DIV = c_div(g), TQ = c_tq(g), OSR = c_osr(g), SG = c_sgn(g);
    localparam int SH = 2 * DIV * DW, FL = TC + SH + TQ, NF = 1 << OSR, OFF = TC + SH - DIV + 1;
    adc_spi_sampler_if #(.N_CH(NC), .DATA_W(DW)) bus ();
    adc_spi_sampler #(.DATA_W(DW), .N_CH(NC), .SCLK_DIV(DIV), .T_CONV(TC), .T_QUIET(TQ),
                      .OSR_LOG2(OSR), .SIGNED(SG))
      dut (.clk(clk), .rst(rst), .enable(enable), .bus(bus));
    bit active = 1'b0;
    int t = 0;
    logic [NC*DW-1:0] exp_data = '0;
    always @(posedge clk or posedge rst)
      if (rst) active <= 1'b0;
      else if (!enable) active <= 1'b0;
      else if (!active) begin
        active <= 1'b1;
        t <= 0;
      end else t <= t + 1;
    always @(negedge clk) begin
      int p, f, k, s;
      bit conv, sc, sh, nd;
      logic [DW-1:0] w;
      p = t % FL;
      f = (t / FL) % NFR;
      k = (p - TC) / (2 * DIV);
      sh = active && p >= TC && p < TC + SH;
      conv = active && p < TC;
      sc = sh && ((p - TC) / DIV) % 2 == 0;
      nd = active && p == OFF && f % NF == NF - 1;
      if (rst) exp_data = '0;
      else if (nd)
        for (int c = 0; c < NC; c++) begin
          s = 0;
          for (int j = 0; j < NF; j++) begin
            w = words[g][f-NF+1+j][c];
            s += SG != 0 ? int'($signed(w ^ 16'h8000)) : int'(w);
          end
          exp_data[c*DW +: DW] = DW'(s >>> OSR);
        end
      check($sformatf("i%0d.convst", g), bus.CONVST, conv);
      check($sformatf("i%0d.sclk", g), bus.SCLK, sc);
      check($sformatf("i%0d.newdata", g), bus.newdata, nd);
      check($sformatf("i%0d.data", g), bus.data, exp_data);
      for (int c = 0; c < NC; c++) bus.SDO[c] = sh ? words[g][f][c][DW-1-k] : 1'b0;
    end
  end
  initial begin
    fill_rand();
    fill_const(0);
    fill_const(3);
    words[2][0][0] = 16'h0000;
    words[2][1][0] = 16'hFFFF;
    words[2][2][0] = 16'h8000;
    for (int j = 0; j < 4; j++) begin
      words[1][j][0] = 16'h8001 + 16'(j);
      words[1][4+j][0] = 16'h7FFF;
    end
    repeat (3) @(negedge clk);
    check("rst.convst", inst[0].bus.CONVST, 0);
    check("rst.sclk", inst[0].bus.SCLK, 0);
    check("rst.data", inst[0].bus.data, 0);
    check("rst.newdata", inst[1].bus.newdata, 0);
    rst = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    for (int c = 0; c < 1300; c++) begin
      @(negedge clk);
      if (c == 35) check("t1.conv_last", inst[0].bus.CONVST, 1);
      if (c == 36) check("t1.sclk_first", inst[0].bus.SCLK, 1);
      if (c == 68) begin
        check("t1.data", inst[0].bus.data, 32'h0001A5C3);
        check("t1.nd", inst[0].bus.newdata, 1);
        check("sg.ch0_f0", inst[2].bus.data[15:0], 16'h8000);
        check("osr.early_nd", inst[1].bus.newdata, 0);
      end
      if (c == 139) check("t1.nd_gap", inst[0].bus.newdata, 0);
      if (c == 140) begin
        check("t1.nd_period", inst[0].bus.newdata, 1);
        check("sg.ch0_f1", inst[2].bus.data[15:0], 16'h7FFF);
      end
      if (c == 212) check("sg.ch0_f2", inst[2].bus.data[15:0], 16'h0000);
      if (c == 130) check("div3.data", inst[3].bus.data, 32'h0001A5C3);
      if (c == 263) check("div3.nd_period", inst[3].bus.newdata, 1);
      if (c == 284) begin
        check("osr.nd", inst[1].bus.newdata, 1);
        check("osr.avg_pos", inst[1].bus.data[15:0], 16'h0002);
      end
      if (c == 572) check("osr.avg_neg", inst[1].bus.data[15:0], 16'hFFFF);
    end
    for (int n = 0; n < 200 && !(inst[0].active && inst[0].t % 72 == 49); n++) @(negedge clk);
    check("abort.reached", inst[0].t % 72, 49);
    enable = 1'b0;
    @(negedge clk);
    check("abort.convst", inst[0].bus.CONVST, 0);
    check("abort.sclk", inst[0].bus.SCLK, 0);
    check("abort.newdata", inst[0].bus.newdata, 0);
    check("abort.data", inst[0].bus.data, 32'h0001A5C3);
    repeat (3) @(negedge clk);
    fill_rand();
    enable = 1'b1;
    @(negedge clk);
    check("reen.convst", inst[0].bus.CONVST, 1);
    check("reen.convst_osr", inst[1].bus.CONVST, 1);
    for (int c = 1; c < 1300; c++) begin
      @(negedge clk);
      if (c == 68) check("reen.no_early_nd", inst[1].bus.newdata, 0);
      if (c == 284) check("reen.osr_nd", inst[1].bus.newdata, 1);
    end
    for (int n = 0; n < 200 && !(inst[0].active && inst[0].t % 72 == 45); n++) @(negedge clk);
    check("rst_mid.reached", inst[0].t % 72, 45);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid.convst", inst[3].bus.CONVST, 0);
    check("rst_mid.sclk", inst[0].bus.SCLK, 0);
    check("rst_mid.data", inst[0].bus.data, 0);
    check("rst_mid.newdata", inst[1].bus.newdata, 0);
    fill_const(0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 1300; c++) begin
      @(negedge clk);
      if (c == 68) check("rst_mid.first_frame", inst[0].bus.data, 32'h0001A5C3);
    end
    for (int s = 0; s < 8; s++) begin
      enable = 1'b0;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      fill_rand();
      enable = 1'b1;
      repeat ($urandom_range(30, 600)) @(negedge clk);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
